wb_sysinfo: RTL and testbench

Parametrised Wishbone classic slave that replaces the single fixed-word version register. It exposes a small read-only identity bank (magic, version, build date, git hash, capability), free-running uptime counters, a control register, and NUM_SCRATCH byte-writable scratch registers. Configurable ack latency. Unmapped offsets terminate with an error. Sits on the system Wishbone bus and is the first block software probes at boot.

---
 rtl/wb_sysinfo_pkg.sv | 38 +++
 rtl/wb_sysinfo_uptime.sv | 38 +++
 rtl/wb_sysinfo.sv | 195 +++++++++++++++++++
 tb/tb_wb_sysinfo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sysinfo_pkg.sv
// Shared definitions for the wb_sysinfo register block: register offsets,
// access FSM states, capability field layout and the address-map decoder.
package wb_sysinfo_pkg;

  localparam logic [7:0] OFF_MAGIC      = 8'h00;
  localparam logic [7:0] OFF_VERSION    = 8'h04;
  localparam logic [7:0] OFF_BUILD_DATE = 8'h08;
  localparam logic [7:0] OFF_GIT_HASH   = 8'h0C;
  localparam logic [7:0] OFF_CAPABILITY = 8'h10;
  localparam logic [7:0] OFF_UPTIME_CYC = 8'h14;
  localparam logic [7:0] OFF_UPTIME_SEC = 8'h18;
  localparam logic [7:0] OFF_CONTROL    = 8'h1C;
  localparam logic [7:0] OFF_SCRATCH0   = 8'h20;

  localparam int unsigned MAX_SCRATCH = 8;

  localparam int unsigned CAP_NS_LSB  = 0;
  localparam int unsigned CAP_LAT_LSB = 4;
  localparam int unsigned CAP_FIELD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Everything below the scratch window is a fixed register; scratch words
  // exist only up to num_scratch. Misaligned offsets never decode.
  function automatic logic is_mapped(input logic [7:0] offset,
                                     input int unsigned num_scratch);
    logic [7:0] rel;
    if (offset[1:0] != 2'b00) return 1'b0;
    if (offset < OFF_SCRATCH0) return 1'b1;
    rel = offset - OFF_SCRATCH0;
    return 32'(rel[7:2]) < num_scratch;
  endfunction

endpackage

// File: rtl/wb_sysinfo_uptime.sv
// Free-running uptime: cycle counter plus a seconds counter driven by a
// CLK_HZ prescaler. A clear pulse zeroes all three and beats any increment.
module wb_sysinfo_uptime #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  output logic [31:0] o_cycles,
  output logic [31:0] o_sec
);

  localparam logic [31:0] PRESC_MAX = 32'(CLK_HZ - 1);

  logic [31:0] r_presc;
  logic [31:0] r_cycles;
  logic [31:0] r_sec;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_presc  <= '0;
      r_cycles <= '0;
      r_sec    <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_sec   <= r_sec + 32'd1;
      end else begin
        r_presc <= r_presc + 32'd1;
      end
    end
  end

  assign o_cycles = r_cycles;
  assign o_sec    = r_sec;

endmodule

// File: rtl/wb_sysinfo.sv
// Wishbone classic slave exposing the system identity bank, uptime counters,
// a control register and byte-writable scratch words with a fixed ack latency.
module wb_sysinfo
  import wb_sysinfo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter logic [31:0] MAGIC       = 32'hDEAD_BEEF,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter logic [31:0] BUILD_DATE  = 32'h2024_0101,
  parameter logic [31:0] GIT_HASH    = 32'h0000_0000,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned ACK_LATENCY = 1,
  parameter int unsigned CLK_HZ      = 100_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam logic [3:0] LAT_M1 = 4'(ACK_LATENCY - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;
  logic        w_enter_resp;

  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [3:0]  r_sel;
  logic        r_we;

  logic [31:0] r_scratch [NUM_SCRATCH];
  logic [31:0] r_dat_o;
  logic        r_ack;
  logic        r_err;

  logic        w_req;
  logic        w_in_idle;
  logic [31:0] w_acc_adr;
  logic [31:0] w_acc_dat;
  logic [3:0]  w_acc_sel;
  logic        w_acc_we;
  logic [7:0]  w_offset;
  logic        w_mapped;
  logic [31:0] w_rd_data;
  logic        w_clr;
  logic        w_scr_wr;
  logic [31:0] w_cycles;
  logic [31:0] w_sec;

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_in_idle = (r_state == ST_IDLE);

  // With a one-cycle latency the response is decided on the sampling edge
  // itself, so the live bus is used there instead of the captured copy.
  assign w_acc_adr = w_in_idle ? wb_adr_i : r_adr;
  assign w_acc_dat = w_in_idle ? wb_dat_i : r_wdat;
  assign w_acc_sel = w_in_idle ? wb_sel_i : r_sel;
  assign w_acc_we  = w_in_idle ? wb_we_i  : r_we;

  assign w_offset = w_acc_adr[7:0];
  assign w_mapped = (w_acc_adr[31:8] == BASE_ADDR[31:8]) &&
                    is_mapped(w_offset, NUM_SCRATCH);

  assign w_clr    = w_enter_resp & w_mapped & w_acc_we &
                    (w_offset == OFF_CONTROL) & w_acc_sel[0] & w_acc_dat[0];
  assign w_scr_wr = w_enter_resp & w_mapped & w_acc_we;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (LAT_M1 == 4'd0) begin
            w_next_state = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_next_state = ST_RESP;
          w_next_cnt   = 4'd0;
          w_enter_resp = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_mapped) begin
      case (w_offset)
        OFF_MAGIC:      w_rd_data = MAGIC;
        OFF_VERSION:    w_rd_data = VERSION;
        OFF_BUILD_DATE: w_rd_data = BUILD_DATE;
        OFF_GIT_HASH:   w_rd_data = GIT_HASH;
        OFF_CAPABILITY: begin
          w_rd_data[CAP_NS_LSB  +: CAP_FIELD_W] = 4'(NUM_SCRATCH);
          w_rd_data[CAP_LAT_LSB +: CAP_FIELD_W] = 4'(ACK_LATENCY);
        end
        OFF_UPTIME_CYC: w_rd_data = w_cycles;
        OFF_UPTIME_SEC: w_rd_data = w_sec;
        OFF_CONTROL:    w_rd_data = '0;
        default: begin
          for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (w_offset == OFF_SCRATCH0 + 8'(4 * i)) w_rd_data = r_scratch[i];
          end
        end
      endcase
    end
  end

  // Request capture and the registered response; outputs are non-zero only
  // during the single RESP cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_adr   <= '0;
      r_wdat  <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      if (w_in_idle && w_req) begin
        r_adr  <= wb_adr_i;
        r_wdat <= wb_dat_i;
        r_sel  <= wb_sel_i;
        r_we   <= wb_we_i;
      end
      r_ack   <= w_enter_resp & w_mapped;
      r_err   <= w_enter_resp & ~w_mapped;
      r_dat_o <= (w_enter_resp & w_mapped & ~w_acc_we) ? w_rd_data : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (!i_rst_n) begin
        r_scratch[i] <= '0;
      end else if (w_scr_wr && (w_offset == OFF_SCRATCH0 + 8'(4 * i))) begin
        for (int b = 0; b < 4; b++) begin
          if (w_acc_sel[b]) r_scratch[i][8*b +: 8] <= w_acc_dat[8*b +: 8];
        end
      end
    end
  end

  wb_sysinfo_uptime #(
    .CLK_HZ (CLK_HZ)
  ) u_uptime (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_clr),
    .o_cycles (w_cycles),
    .o_sec    (w_sec)
  );

  assign wb_dat_o = r_dat_o;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

endmodule

// File: tb/tb_wb_sysinfo.sv
// Bench for wb_sysinfo: two instances (ack latency 1 and 4) on a shared bus
// with separate cyc/stb, scoreboard queues per instance and a register-map model.
module tb_wb_sysinfo;

  localparam int HZ = 10;
  localparam int NS = 4;
  localparam int W  = 34;  // {err, ack, data}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          edge_n = 0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [1:0]  cyc = '0;
  logic [1:0]  stb = '0;
  logic [31:0] rdat0, rdat1;
  logic        ack0, ack1, err0, err1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_scr [2][8];
  int          origin [2];
  int          lat [2] = '{1, 4};

  wb_sysinfo #(.NUM_SCRATCH(NS), .ACK_LATENCY(1), .CLK_HZ(HZ)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]),
    .wb_dat_o(rdat0), .wb_ack_o(ack0), .wb_err_o(err0));

  wb_sysinfo #(.NUM_SCRATCH(NS), .ACK_LATENCY(4), .CLK_HZ(HZ)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]),
    .wb_dat_o(rdat1), .wb_ack_o(ack1), .wb_err_o(err1));

  // ---------------- clock / reset ----------------
  // edge_n is bumped just before each rising edge, so it names that edge.
  initial begin
    forever begin
      #5 edge_n++; clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset_state(int org);
    for (int d = 0; d < 2; d++) begin
      origin[d] = org;
      for (int i = 0; i < 8; i++) m_scr[d][i] = '0;
    end
  endtask

  // ---------------- reference model ----------------
  // snap is the edge on which read data is registered (sample edge + L - 1).
  function automatic logic [W-1:0] model(int d, logic [31:0] a, logic w,
                                         logic [31:0] dv, logic [3:0] s, int snap);
    int          off  = int'(a[7:0]);
    int          word = off / 4;
    int          cyc_v;
    logic [31:0] v = '0;
    logic [7:0]  capv;
    bit          mapped = (a[31:8] == 24'h000001) && (off % 4 == 0) && (word < 8 + NS);
    if (!mapped) return {1'b1, 1'b0, 32'h0};
    if (w) begin
      if (word >= 8)
        for (int b = 0; b < 4; b++)
          if (s[b]) m_scr[d][word-8][8*b +: 8] = dv[8*b +: 8];
      if (word == 7 && s[0] && dv[0]) origin[d] = snap + 1;
      return {1'b0, 1'b1, 32'h0};
    end
    cyc_v = snap - origin[d];
    capv  = 8'(lat[d] * 16 + NS);
    case (word)
      0: v = 32'hDEAD_BEEF;
      1: v = 32'h0001_0000;
      2: v = 32'h2024_0101;
      3: v = 32'h0000_0000;
      4: v = {24'h0, capv};
      5: v = 32'(cyc_v);
      6: v = 32'(cyc_v / HZ);
      7: v = 32'h0;
      default: v = m_scr[d][word-8];
    endcase
    return {1'b0, 1'b1, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic access(int d, logic [31:0] a, logic w, logic [31:0] dv, logic [3:0] s);
    int e0;
    int n = 0;
    bit got = 0;
    @(negedge clk);
    adr = a; wdat = dv; sel = s; we = w;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    e0 = edge_n + 1;
    if (d == 0) exp_q0.push_back(model(d, a, w, dv, s, e0 + lat[d] - 1));
    else        exp_q1.push_back(model(d, a, w, dv, s, e0 + lat[d] - 1));
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (d == 0 ? (ack0 | err0) : (ack1 | err1)) got = 1;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout dut%0d adr %h: got no response in 40 cycles, required ack or err", d, a);
    end else begin
      check($sformatf("latency_dut%0d", d), W'(edge_n - e0 + 1), W'(lat[d]));
      @(posedge clk);
    end
  endtask

  // Starts a read, then after 'hold' sampled edges drops cyc (or asserts reset);
  // no response may follow.
  task automatic abort_access(int d, logic [31:0] a, int hold, bit use_reset);
    int n_resp = 0;
    @(negedge clk);
    adr = a; we = 1'b0; sel = 4'hF; wdat = '0;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    repeat (hold) @(negedge clk);
    if (use_reset) rst_n = 1'b0;
    else begin cyc[d] = 1'b0; stb[d] = 1'b0; end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (d == 0 ? (ack0 | err0) : (ack1 | err1)) n_resp++;
      if (use_reset && i == 2) begin
        @(negedge clk);
        cyc[d] = 1'b0; stb[d] = 1'b0; rst_n = 1'b1;
        model_reset_state(edge_n + 1);
      end
    end
    check($sformatf("abort_no_resp_dut%0d", d), W'(n_resp), W'(0));
  endtask

  // ---------------- scoreboard monitors ----------------
  task automatic mon(int d, logic a, logic e, logic [31:0] dv);
    logic [W-1:0] exp;
    check($sformatf("ack_err_exclusive_dut%0d", d), W'(a & e), W'(0));
    if (a | e) begin
      if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_resp dut%0d: got ack=%b err=%b, required no response", d, a, e);
      end else begin
        exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("resp_dut%0d", d), {e, a, dv}, exp);
      end
    end else begin
      check($sformatf("idle_dat_dut%0d", d), W'(dv), W'(0));
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, ack0, err0, rdat0);
    mon(1, ack1, err1, rdat1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          r;
    model_reset_state(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_dut0", {err0, ack0, rdat0}, W'(0));
    check("reset_outputs_dut1", {err1, ack1, rdat1}, W'(0));
    rst_n = 1'b1;
    model_reset_state(edge_n + 1);

    // identity reads on both latencies
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) access(d, 32'h100 + 32'(4 * i), 1'b0, '0, 4'hF);

    // byte-lane scratch write
    for (int d = 0; d < 2; d++) begin
      access(d, 32'h120, 1'b1, 32'hFFFF_FFFF, 4'hF);
      access(d, 32'h120, 1'b1, 32'hA5A5_1234, 4'b0101);
      access(d, 32'h120, 1'b0, '0, 4'hF);
    end

    // unmapped: missing scratch, misaligned, wrong base; RO write ignored
    for (int d = 0; d < 2; d++) begin
      access(d, 32'h140, 1'b0, '0, 4'hF);
      access(d, 32'h102, 1'b0, '0, 4'hF);
      access(d, 32'h200, 1'b0, '0, 4'hF);
      access(d, 32'h12C, 1'b1, 32'h1357_9BDF, 4'hF);
      access(d, 32'h130, 1'b1, 32'h1, 4'hF);
      access(d, 32'h100, 1'b1, 32'h1234_5678, 4'hF);
      access(d, 32'h100, 1'b0, '0, 4'hF);
      access(d, 32'h11C, 1'b0, '0, 4'hF);
    end

    // uptime and control clear
    repeat (35) @(negedge clk);
    access(0, 32'h118, 1'b0, '0, 4'hF);
    access(0, 32'h11C, 1'b1, 32'h1, 4'hF);
    access(0, 32'h114, 1'b0, '0, 4'hF);
    access(0, 32'h118, 1'b0, '0, 4'hF);
    access(1, 32'h118, 1'b0, '0, 4'hF);
    access(1, 32'h11C, 1'b1, 32'h1, 4'hF);
    access(1, 32'h114, 1'b0, '0, 4'hF);
    access(1, 32'h11C, 1'b1, 32'h1, 4'hE);
    access(1, 32'h114, 1'b0, '0, 4'hF);

    // abort by dropping cyc, then a normal access
    abort_access(1, 32'h104, 2, 1'b0);
    access(1, 32'h104, 1'b0, '0, 4'hF);
    abort_access(0, 32'h104, 0, 1'b0);

    // reset in WAIT: no response, state cleared afterwards
    access(1, 32'h124, 1'b1, 32'hCAFE_F00D, 4'hF);
    abort_access(1, 32'h104, 1, 1'b1);
    access(1, 32'h124, 1'b0, '0, 4'hF);
    access(1, 32'h110, 1'b0, '0, 4'hF);
    access(0, 32'h110, 1'b0, '0, 4'hF);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h100 + 32'($urandom_range(0, 255));
      else if (r == 1) a = 32'h200 + 32'(4 * $urandom_range(0, 15));
      else             a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      access($urandom_range(0, 1), a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    check("queue_drained_dut0", W'(exp_q0.size()), W'(0));
    check("queue_drained_dut1", W'(exp_q1.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
